// File: rtl/mc_controller_hs_pkg.sv
// Shared encodings for the handshaked multicycle controller: stage codes,
// instruction codes, datapath select values and the decoder output bundle.
package mc_controller_hs_pkg;

  typedef enum logic [2:0] {
    STAGE_IF     = 3'd0,
    STAGE_DECODE = 3'd1,
    STAGE_EXE    = 3'd2,
    STAGE_MEM    = 3'd3,
    STAGE_WB     = 3'd4,
    STAGE_HALT   = 3'd5,
    STAGE_FAULT  = 3'd6
  } stage_e;

  localparam logic [5:0] INST_NOP   = 6'd0,  INST_ADDU  = 6'd1,  INST_SUBU = 6'd2,
                         INST_ORI   = 6'd3,  INST_LW    = 6'd4,  INST_SW   = 6'd5,
                         INST_BEQ   = 6'd6,  INST_LUI   = 6'd7,  INST_J    = 6'd8,
                         INST_ADDI  = 6'd9,  INST_ADDIU = 6'd10, INST_SLT  = 6'd11,
                         INST_JAL   = 6'd12, INST_JR    = 6'd13, INST_SB   = 6'd14,
                         INST_LB    = 6'd15, INST_HLT   = 6'd16;

  localparam logic [1:0] ALU_SEL_ADD = 2'd0, ALU_SEL_SUB = 2'd1,
                         ALU_SEL_OR  = 2'd2, ALU_SEL_SLT = 2'd3;
  localparam logic [1:0] GPR_WRITE_RT = 2'd0, GPR_WRITE_RD = 2'd1, GPR_WRITE_RA = 2'd2;
  localparam logic [1:0] GPR_WRITE_ALU = 2'd0, GPR_WRITE_MEM = 2'd1, GPR_WRITE_PC = 2'd2;
  localparam logic [1:0] EXT_SEL_ZERO = 2'd0, EXT_SEL_SIGN = 2'd1, EXT_SEL_UPPER = 2'd2;
  localparam logic [1:0] IFU_SEL_NORM = 2'd0, IFU_SEL_RELATIVE = 2'd1,
                         IFU_SEL_ABS  = 2'd2, IFU_SEL_REG      = 2'd3;
  localparam logic       DM_WORD = 1'b0, DM_BYTE = 1'b1;

  typedef struct packed {
    logic [1:0] alu_sel;
    logic [1:0] gpr_write_addr_sel;
    logic [1:0] gpr_write_data_sel;
    logic       alu_src_ctl;
    logic [1:0] ext_ctl;
    logic [1:0] npc_sel;
    logic       dm_sel;
    logic       alu_wb;
    logic       addi;
    logic       load;
    logic       store;
    logic       jump;
    logic       branch;
    logic       nop;
    logic       halt;
    logic       illegal;
  } dec_ctl_t;

endpackage

// File: rtl/mc_controller_hs_inst_ctrl_decode.sv
// Purely combinational instruction decode: datapath selects plus the class
// bits the sequencer uses to pick the next stage.
module inst_ctrl_decode
  import mc_controller_hs_pkg::*;
(
  input  logic [5:0] dec_inst,
  output dec_ctl_t   ctl
);

  always_comb begin
    ctl = '0;
    ctl.alu_sel            = ALU_SEL_ADD;
    ctl.gpr_write_addr_sel = GPR_WRITE_RT;
    ctl.gpr_write_data_sel = GPR_WRITE_ALU;
    ctl.ext_ctl            = EXT_SEL_ZERO;
    ctl.npc_sel            = IFU_SEL_NORM;
    ctl.dm_sel             = DM_WORD;
    case (dec_inst)
      INST_NOP:   ctl.nop = 1'b1;
      INST_ADDU:  begin ctl.gpr_write_addr_sel = GPR_WRITE_RD; ctl.alu_wb = 1'b1; end
      INST_SUBU:  begin ctl.alu_sel = ALU_SEL_SUB; ctl.gpr_write_addr_sel = GPR_WRITE_RD; ctl.alu_wb = 1'b1; end
      INST_ORI:   begin ctl.alu_sel = ALU_SEL_OR; ctl.alu_src_ctl = 1'b1; ctl.alu_wb = 1'b1; end
      INST_LW:    begin ctl.alu_src_ctl = 1'b1; ctl.ext_ctl = EXT_SEL_SIGN;
                        ctl.gpr_write_data_sel = GPR_WRITE_MEM; ctl.load = 1'b1; end
      INST_SW:    begin ctl.alu_src_ctl = 1'b1; ctl.ext_ctl = EXT_SEL_SIGN; ctl.store = 1'b1; end
      INST_BEQ:   begin ctl.alu_sel = ALU_SEL_SUB; ctl.ext_ctl = EXT_SEL_SIGN;
                        ctl.npc_sel = IFU_SEL_RELATIVE; ctl.branch = 1'b1; end
      INST_LUI:   begin ctl.alu_src_ctl = 1'b1; ctl.ext_ctl = EXT_SEL_UPPER; ctl.alu_wb = 1'b1; end
      INST_J:     begin ctl.npc_sel = IFU_SEL_ABS; ctl.jump = 1'b1; end
      INST_ADDI:  begin ctl.alu_src_ctl = 1'b1; ctl.ext_ctl = EXT_SEL_SIGN;
                        ctl.alu_wb = 1'b1; ctl.addi = 1'b1; end
      INST_ADDIU: begin ctl.alu_src_ctl = 1'b1; ctl.ext_ctl = EXT_SEL_SIGN; ctl.alu_wb = 1'b1; end
      INST_SLT:   begin ctl.alu_sel = ALU_SEL_SLT; ctl.gpr_write_addr_sel = GPR_WRITE_RD; ctl.alu_wb = 1'b1; end
      INST_JAL:   begin ctl.gpr_write_addr_sel = GPR_WRITE_RA; ctl.gpr_write_data_sel = GPR_WRITE_PC;
                        ctl.npc_sel = IFU_SEL_ABS; ctl.jump = 1'b1; ctl.alu_wb = 1'b1; end
      INST_JR:    begin ctl.npc_sel = IFU_SEL_REG; ctl.jump = 1'b1; end
      INST_SB:    begin ctl.alu_src_ctl = 1'b1; ctl.ext_ctl = EXT_SEL_SIGN;
                        ctl.dm_sel = DM_BYTE; ctl.store = 1'b1; end
      INST_LB:    begin ctl.alu_src_ctl = 1'b1; ctl.ext_ctl = EXT_SEL_SIGN; ctl.dm_sel = DM_BYTE;
                        ctl.gpr_write_data_sel = GPR_WRITE_MEM; ctl.load = 1'b1; end
      INST_HLT:   ctl.halt = 1'b1;
      default:    ctl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle controller with req/ready memory handshakes, a handshake
// watchdog, optional ADDI overflow trap, sticky HALT/FAULT and perf counters.
module mc_controller_hs
  import mc_controller_hs_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200,
  parameter int OVF_TRAP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       dec_inst,
  input  logic             zero,
  input  logic             ovf,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write_en,
  output logic             pc_write_en,
  output logic             reg_write_en,
  output logic             dmem_req,
  output logic             mem_write_en,
  output logic [1:0]       alu_sel,
  output logic [1:0]       gpr_write_addr_sel,
  output logic [1:0]       gpr_write_data_sel,
  output logic             alu_src_ctl,
  output logic [1:0]       ext_ctl,
  output logic [1:0]       npc_sel,
  output logic             dm_sel,
  output logic [2:0]       stage,
  output logic             halted,
  output logic             bus_error,
  output logic             ovf_trap,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic                 WD_EN   = (TIMEOUT > 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  dec_ctl_t ctl;
  inst_ctrl_decode u_dec (.dec_inst(dec_inst), .ctl(ctl));

  stage_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]     cycle_q, cycle_d, retired_q, retired_d;
  logic                 illegal_q, ovf_trap_q;
  logic                 set_ill, set_ovf, retire, hs_wait;
  logic                 ir_we_c, pc_we_c, reg_we_c, mem_we_c;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    retire   = 1'b0;
    set_ill  = 1'b0;
    set_ovf  = 1'b0;
    hs_wait  = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_we_c  = 1'b0;
    pc_we_c  = 1'b0;
    reg_we_c = 1'b0;
    mem_we_c = 1'b0;
    case (state_q)
      STAGE_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = STAGE_DECODE;
        end else begin
          hs_wait = 1'b1;
        end
      end
      STAGE_DECODE: begin
        if (ctl.nop) begin
          state_d = STAGE_IF;
          retire  = 1'b1;
        end else if (ctl.halt) begin
          state_d = STAGE_HALT;
        end else if (ctl.illegal) begin
          set_ill = 1'b1;
          state_d = STAGE_IF;
          retire  = 1'b1;
        end else begin
          state_d = STAGE_EXE;
        end
      end
      STAGE_EXE: begin
        pc_we_c = ctl.jump | (ctl.branch & zero);
        if (ctl.addi && (OVF_TRAP != 0) && ovf) begin
          set_ovf = 1'b1;
          state_d = STAGE_IF;
          retire  = 1'b1;
        end else if (ctl.alu_wb) begin
          state_d = STAGE_WB;
        end else if (ctl.load || ctl.store) begin
          state_d = STAGE_MEM;
        end else begin
          state_d = STAGE_IF;
          retire  = 1'b1;
        end
      end
      STAGE_MEM: begin
        dmem_req = 1'b1;
        mem_we_c = ctl.store;
        if (dmem_ready) begin
          state_d = ctl.load ? STAGE_WB : STAGE_IF;
          retire  = ~ctl.load;
        end else begin
          hs_wait = 1'b1;
        end
      end
      STAGE_WB: begin
        reg_we_c = 1'b1;
        state_d  = STAGE_IF;
        retire   = 1'b1;
      end
      STAGE_HALT, STAGE_FAULT: state_d = state_q;
      default: state_d = STAGE_IF;
    endcase

    // A ready arriving on the last permitted wait cycle wins over the fault.
    if (hs_wait) begin
      if (WD_EN && wait_q == TO_LAST) begin
        state_d = STAGE_FAULT;
        wait_d  = '0;
      end else begin
        wait_d = wait_q + TIMEOUT_W'(1);
      end
    end else if (state_d != state_q) begin
      wait_d = '0;
    end

    cycle_d   = cycle_q;
    retired_d = retired_q;
    if (state_q != STAGE_HALT && state_q != STAGE_FAULT) cycle_d = cycle_q + CNT_W'(1);
    if (retire) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STAGE_IF;
      wait_q     <= '0;
      cycle_q    <= '0;
      retired_q  <= '0;
      illegal_q  <= 1'b0;
      ovf_trap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      cycle_q    <= cycle_d;
      retired_q  <= retired_d;
      illegal_q  <= illegal_q | set_ill;
      ovf_trap_q <= ovf_trap_q | set_ovf;
    end
  end

  // Write strobes are masked while reset is held so nothing commits mid-reset.
  assign ir_write_en        = ir_we_c & ~reset;
  assign pc_write_en        = pc_we_c & ~reset;
  assign reg_write_en       = reg_we_c & ~reset;
  assign mem_write_en       = mem_we_c & ~reset;
  assign alu_sel            = ctl.alu_sel;
  assign gpr_write_addr_sel = ctl.gpr_write_addr_sel;
  assign gpr_write_data_sel = ctl.gpr_write_data_sel;
  assign alu_src_ctl        = ctl.alu_src_ctl;
  assign ext_ctl            = ctl.ext_ctl;
  assign npc_sel            = (state_q == STAGE_IF) ? IFU_SEL_NORM : ctl.npc_sel;
  assign dm_sel             = ctl.dm_sel;
  assign stage              = state_q;
  assign halted             = (state_q == STAGE_HALT);
  assign bus_error          = (state_q == STAGE_FAULT);
  assign ovf_trap           = ovf_trap_q;
  assign illegal            = illegal_q;
  assign cycle_count        = cycle_q;
  assign retired_count      = retired_q;

endmodule

// File: doc/mc_controller_hs.md
Name: mc_controller_hs

Overview:
Parametrised successor to the fixed-latency multicycle MIPS controller. It sequences IF/DECODE/EXE/MEM/WB and drives the same datapath control selects. It adds:
- req/ready handshakes to instruction and data memory, so memories may take variable latency;
- a handshake watchdog;
- an optional ADDI overflow trap;
- a sticky HALT state;
- performance counters.

It sits between the instruction register decode and the datapath, replacing the old controller.

Parameters:
CNT_W, 32, width of cycle and retired-instruction counters
TIMEOUT_W, 8, width of handshake wait counter
TIMEOUT, 200, cycles waited for ready before fault; 0 disables watchdog
OVF_TRAP, 1, 1: ADDI overflow suppresses writeback and sets ovf_trap; 0: ADDI writes normally

Ports:
clk in 1 system clock; reset is synchronous and active-high
reset in 1 synchronous active-high reset
dec_inst in 6 decoded instruction code (INST_* encodings from shared defines)
zero in 1 ALU zero flag
ovf in 1 ALU signed overflow flag
imem_ready in 1 instruction memory accepts/returns fetch
dmem_ready in 1 data memory completes access
imem_req out 1 fetch request
ir_write_en out 1 latch fetched instruction
pc_write_en out 1 PC update strobe
reg_write_en out 1 GPR write strobe
dmem_req out 1 data access request
mem_write_en out 1 data write qualifier
alu_sel out 2; gpr_write_addr_sel out 2; gpr_write_data_sel out 2; alu_src_ctl out 1; ext_ctl out 2; npc_sel out 2; dm_sel out 1 datapath selects, same encodings as before
stage out 3 current state
halted out 1 sticky, HLT executed
bus_error out 1 sticky, watchdog expired
ovf_trap out 1 sticky, ADDI overflow trapped
illegal out 1 sticky, unknown dec_inst decoded
cycle_count out CNT_W running cycle count
retired_count out CNT_W completed instruction count

Behaviour:
- Reset (sampled at posedge clk): state=IF, wait_cnt=0, both counters 0, all sticky flags 0. Strobes are combinational from state, so all are 0 except imem_req=1 in IF.
- IF:
  - imem_req=1, npc_sel=NORM.
  - imem_ready=1: pc_write_en=1 and ir_write_en=1 for that cycle, then next DECODE.
  - Otherwise stay in IF and increment wait_cnt.
- DECODE:
  - NOP: go to IF, retire.
  - HLT: go to HALT, do not retire.
  - Unknown code: set illegal, go to IF, retire, no writes.
  - Anything else: go to EXE.
- EXE:
  - Selects are decoded from dec_inst exactly as before (ADDU, SUBU, ORI, LW, SW, BEQ, LUI, J, ADDI, ADDIU, SLT, JAL, JR, SB, LB).
  - pc_write_en=1 for J, JAL, JR, and for BEQ when zero=1.
  - ADDU, SUBU, ORI, LUI, ADDIU, SLT, JAL: go to WB.
  - ADDI: go to WB; if OVF_TRAP=1 and ovf=1, instead set ovf_trap, go to IF and retire.
  - LW, LB, SW, SB: go to MEM.
  - J, JR, BEQ: go to IF, retire.
- MEM:
  - dmem_req=1; mem_write_en=1 for SW/SB; dm_sel held stable.
  - dmem_ready=1: loads go to WB; stores go to IF and retire.
  - Otherwise stay in MEM and increment wait_cnt.
- WB: reg_write_en=1 for exactly one cycle, then IF, retire.
- HALT: absorbing; halted=1, all strobes 0, counters frozen. Only reset exits.
- FAULT: absorbing; bus_error=1, all strobes 0, counters frozen. Only reset exits.
- Watchdog:
  - wait_cnt clears on every state change.
  - In IF or MEM with ready=0 and wait_cnt==TIMEOUT-1, go to FAULT next cycle.
  - ready=1 in that same cycle wins; no fault.
  - TIMEOUT=0 disables the watchdog entirely.
- Counters:
  - cycle_count increments every cycle outside HALT/FAULT and wraps modulo 2^CNT_W.
  - retired_count increments on each retiring transition and also wraps.
- Request stability: requests are held until their ready; dec_inst is stable from DECODE through WB (IR is held).
- Reset mid-handshake: the request drops on the cycle after reset is sampled; no strobe asserts during reset.

Decomposition:
- Package/defines: STAGE_* codes (IF, DECODE, EXE, MEM, WB, HALT, FAULT), INST_*, ALU_SEL_*, GPR_WRITE_*, EXT_SEL_*, IFU_SEL_*, DM_* constants.
- One sub-module, inst_ctrl_decode: purely combinational dec_inst -> datapath selects plus class bits (alu_wb, load, store, branch/jump, illegal).
- The top holds the FSM, watchdog, counters and sticky flags.

Test Plan:
1. ADDU with imem_ready and dmem_ready tied 1 -> IF, DECODE, EXE, WB, IF (4 cycles); reg_write_en high exactly in the WB cycle; retired_count=1.
2. LW with dmem_ready asserted 3 cycles after MEM entry -> dmem_req held 4 cycles, then WB with gpr_write_data_sel=MEM; total 8 cycles.
3. TIMEOUT=4, imem_ready=0 forever -> FAULT after 4 IF cycles; bus_error=1; cycle_count frozen at 4; reset returns to IF with all counters 0.
4. ADDI with ovf=1, OVF_TRAP=1 -> no reg_write_en, ovf_trap=1, back to IF after EXE. Same with OVF_TRAP=0 -> WB write occurs.
5. BEQ with zero=1 -> pc_write_en in EXE with npc_sel=RELATIVE. With zero=0 -> no pc_write_en in EXE. Both retire in 3 cycles.
6. HLT -> halted=1 from the cycle after DECODE, strobes 0 for 100 cycles. Reset asserted mid-MEM (SW with dmem_ready=0) -> mem_write_en and dmem_req low the next cycle, state IF.
